// File: rtl/rr_bus_arbiter.sv
// Round-robin owner of the shared address/data/nRead/nWrite bus; grant is registered one edge after req,
// with one idle TURN cycle between owners and a forced revoke after MAX_HOLD granted cycles.
module rr_bus_arbiter #(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 256,
    parameter int MAX_HOLD = 64,
    parameter int IDX_W    = $clog2(NREQ)
) (
    input  logic                     Clk,
    input  logic                     nReset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   m_address,
    input  logic [NREQ-1:0]          m_nRead,
    input  logic [NREQ-1:0]          m_nWrite,
    input  logic [NREQ*DATA_W-1:0]   m_data,
    output logic [NREQ-1:0]          gnt,
    output logic [IDX_W-1:0]         owner,
    output logic                     busy,
    output logic [ADDR_W-1:0]        address,
    output logic                     nRead,
    output logic                     nWrite,
    output logic [DATA_W-1:0]        ExeDataOut,
    output logic                     timeout_err,
    output logic [IDX_W-1:0]         timeout_idx
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    state_t             r_state, w_state_nxt;
    logic [NREQ-1:0]    r_gnt, w_gnt_nxt, w_onehot;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   r_tidx, w_tidx_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_terr, w_terr_nxt;
    logic [IDX_W-1:0]   w_win;
    logic               w_found;

    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        return (v >= NREQ) ? IDX_W'(v - NREQ) : IDX_W'(v);
    endfunction

    // First set request at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[f_wrap(int'(r_ptr) + i)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(int'(r_ptr) + i);
            end
        end
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_tidx_nxt  = r_tidx;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_terr_nxt  = 1'b0;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = w_onehot;
                    w_owner_nxt = w_win;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_GRANT: begin
                if (!req[r_owner] || r_cnt >= CNT_W'(MAX_HOLD)) begin
                    w_state_nxt = S_TURN;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = f_wrap(int'(r_owner) + 1);
                    if (req[r_owner]) begin
                        w_terr_nxt = 1'b1;
                        w_tidx_nxt = r_owner;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_tidx  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_tidx  <= w_tidx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    // Only the registered owner's slice can ever reach the shared bus.
    always_comb begin
        address    = '0;
        nRead      = 1'b1;
        nWrite     = 1'b1;
        ExeDataOut = '0;
        if (r_busy) begin
            address    = m_address[int'(r_owner)*ADDR_W +: ADDR_W];
            nRead      = m_nRead[r_owner];
            nWrite     = m_nWrite[r_owner];
            ExeDataOut = m_data[int'(r_owner)*DATA_W +: DATA_W];
        end
    end

    assign gnt         = r_gnt;
    assign owner       = r_owner;
    assign busy        = r_busy;
    assign timeout_err = r_terr;
    assign timeout_idx = r_tidx;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: reset, round-robin order, bus isolation, timeout and async reset.
module tb_rr_bus_arbiter;

    localparam int NREQ = 3, ADDR_W = 16, DATA_W = 256, MAX_HOLD = 24, IDX_W = 2;

    logic                    Clk;
    logic                    nReset;
    logic [NREQ-1:0]         req;
    logic [NREQ*ADDR_W-1:0]  m_address;
    logic [NREQ-1:0]         m_nRead, m_nWrite;
    logic [NREQ*DATA_W-1:0]  m_data;
    logic [NREQ-1:0]         gnt;
    logic [IDX_W-1:0]        owner, timeout_idx;
    logic                    busy, nRead, nWrite, timeout_err;
    logic [ADDR_W-1:0]       address;
    logic [DATA_W-1:0]       ExeDataOut;

    int vectors = 0;
    int miscompares = 0;

    rr_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .nReset(nReset), .req(req), .m_address(m_address), .m_nRead(m_nRead),
        .m_nWrite(m_nWrite), .m_data(m_data), .gnt(gnt), .owner(owner), .busy(busy),
        .address(address), .nRead(nRead), .nWrite(nWrite), .ExeDataOut(ExeDataOut),
        .timeout_err(timeout_err), .timeout_idx(timeout_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [255:0] pat_a;
    int           ord [4] = '{0, 1, 2, 0};

    initial begin
        pat_a     = {8{32'hA5C3_0F01}};
        nReset    = 1'b0;
        req       = 3'b111;
        m_address = '0;
        m_address[0  +: 16] = 16'h1000;
        m_address[16 +: 16] = 16'h2000;
        m_address[32 +: 16] = 16'h3000;
        m_nRead   = '1;
        m_nWrite  = '1;
        m_data    = '0;
        #12;
        chk("rst_gnt",    gnt, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_owner",  owner, 0);
        chk("rst_nRead",  nRead, 1);
        chk("rst_nWrite", nWrite, 1);
        chk("rst_addr",   address, 0);
        chk("rst_data",   ExeDataOut, 0);
        chk("rst_terr",   timeout_err, 0);
        chk("rst_tidx",   timeout_idx, 0);

        @(negedge Clk);
        nReset = 1'b1;
        tick();
        // Order 0,1,2,0: each holds 4 granted cycles, exactly one idle cycle between owners.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk("rr_gnt",   gnt, 3'b001 << ord[k]);
                chk("rr_owner", owner, ord[k]);
                chk("rr_busy",  busy, 1);
                if (c < 3) tick();
            end
            req[ord[k]] = 1'b0;
            tick();
            chk("rr_turn_gnt",  gnt, 0);
            chk("rr_turn_busy", busy, 0);
            req[ord[k]] = 1'b1;
            tick();
        end
        chk("rr_next", gnt, 3'b010);
        req = 3'b000;
        tick();
        tick();

        m_address[16 +: 16] = 16'h2011;
        m_nWrite[1]         = 1'b0;
        req                 = 3'b010;
        tick();
        chk("single_gnt",    gnt, 3'b010);
        chk("single_owner",  owner, 1);
        chk("single_addr",   address, 16'h2011);
        chk("single_nWrite", nWrite, 0);
        chk("single_nRead",  nRead, 1);
        req         = 3'b000;
        m_nWrite[1] = 1'b1;
        tick();
        chk("single_rel_busy",   busy, 0);
        chk("single_rel_nWrite", nWrite, 1);
        tick();

        m_data[0 +: 256] = pat_a;
        req              = 3'b001;
        tick();
        m_address[32 +: 16] = 16'h8003;
        m_nRead[2]          = 1'b0;
        req[2]              = 1'b1;
        m_nWrite[0]         = 1'b0;
        #1;
        chk("iso_gnt",    gnt, 3'b001);
        chk("iso_nRead",  nRead, 1);
        chk("iso_addr",   address, 16'h1000);
        chk("iso_nWrite", nWrite, 0);
        chk("iso_data",   ExeDataOut, pat_a);
        req[0]      = 1'b0;
        m_nWrite[0] = 1'b1;
        tick();
        chk("iso_turn_gnt", gnt, 0);
        tick();
        chk("iso_m2_gnt",   gnt, 3'b100);
        chk("iso_m2_nRead", nRead, 0);
        chk("iso_m2_addr",  address, 16'h8003);
        req        = 3'b000;
        m_nRead[2] = 1'b1;
        tick();
        tick();

        req = 3'b011;
        tick();
        for (int c = 1; c <= MAX_HOLD; c++) begin
            chk("to_hold_gnt", gnt, 3'b001);
            chk("to_hold_err", timeout_err, 0);
            if (c < MAX_HOLD) tick();
        end
        tick();
        chk("to_rev_gnt",  gnt, 0);
        chk("to_rev_busy", busy, 0);
        chk("to_rev_err",  timeout_err, 1);
        chk("to_rev_idx",  timeout_idx, 0);
        tick();
        chk("to_m1_gnt",  gnt, 3'b010);
        chk("to_err_off", timeout_err, 0);
        chk("to_idx_hold", timeout_idx, 0);
        req[1] = 1'b0;
        tick();
        chk("to_turn_gnt", gnt, 0);
        tick();
        chk("to_m0_again", gnt, 3'b001);

        req[0] = 1'b0;
        tick();
        req         = 3'b100;
        m_nWrite[2] = 1'b0;
        tick();
        chk("ar_m2_gnt",    gnt, 3'b100);
        chk("ar_m2_nWrite", nWrite, 0);
        #2;
        nReset = 1'b0;
        #1;
        chk("ar_gnt",    gnt, 0);
        chk("ar_busy",   busy, 0);
        chk("ar_nWrite", nWrite, 1);
        chk("ar_addr",   address, 0);
        chk("ar_owner",  owner, 0);
        #1;
        nReset      = 1'b1;
        req         = 3'b101;
        m_nWrite[2] = 1'b1;
        tick();
        chk("ar_ptr0_gnt", gnt, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Shares the single 16-bit address, 256-bit data, nRead/nWrite memory/Matrix-ALU bus between NREQ bus masters.
- Masters are the execution engine, an instruction/data loader and a debug port.
- Round-robin arbitration with a registered grant, one idle turnaround cycle between owners, and a maximum-tenure watchdog.
- Sits between the masters and the main memory, instruction memory and Matrix ALU address decoders.

Parameters:
NREQ, 3, number of requesting masters (2..8)
ADDR_W, 16, bus address width
DATA_W, 256, bus write-data width
MAX_HOLD, 64, maximum consecutive granted cycles before forced revoke (>= 24, covers a full matrix operation)
IDX_W, $clog2(NREQ), width of owner index

Ports:
Clk  input  1  clock; all state changes on posedge
nReset  input  1  asynchronous active-low reset
req  input  NREQ  per-master bus request, level; held for whole tenure
m_address  input  NREQ*ADDR_W  per-master address, packed, master 0 in LSBs
m_nRead  input  NREQ  per-master read strobe, active low
m_nWrite  input  NREQ  per-master write strobe, active low
m_data  input  NREQ*DATA_W  per-master write data, packed
gnt  output  NREQ  one-hot grant, registered
owner  output  IDX_W  index of current owner; valid only when busy=1
busy  output  1  a grant is active
address  output  ADDR_W  shared bus address
nRead  output  1  shared bus read strobe
nWrite  output  1  shared bus write strobe
ExeDataOut  output  DATA_W  shared bus write data
timeout_err  output  1  one-cycle pulse on forced revoke
timeout_idx  output  IDX_W  master revoked by the last timeout; holds until the next timeout

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-tenure. While reset is held:
  - gnt=0, busy=0, owner=0, timeout_err=0, timeout_idx=0.
  - Round-robin pointer=0, hold counter=0, state=IDLE.
  - Bus outputs idle.
- Bus idle value: nRead=1, nWrite=1, address=0, ExeDataOut=0.
- Bus path is combinational from the registered owner:
  - busy=1: address/nRead/nWrite/ExeDataOut = the owner's m_* slice.
  - busy=0: bus idle value.
  - Strobes from non-owners are ignored and never reach the bus.
- State machine: IDLE, GRANT, TURN.
  - IDLE: if any req bit is set, pick the winner, set gnt[winner], owner=winner, busy=1, hold counter=1, go to GRANT. Grant latency is one cycle: req seen at edge N gives gnt high after edge N+1.
  - GRANT, owner's req still 1 and hold counter < MAX_HOLD: stay, counter++.
  - GRANT, owner's req drops to 0: clear gnt/busy, pointer=owner+1 (mod NREQ), go to TURN.
  - GRANT, counter == MAX_HOLD with req still 1: forced revoke. Clear gnt/busy, pulse timeout_err for one cycle, timeout_idx=owner, pointer=owner+1, go to TURN.
  - TURN: one cycle with the bus idle, so no two owners drive in adjacent cycles. Then go to IDLE, which arbitrates that same cycle's req.
- Winner selection: first set req bit searching upward from the pointer, wrapping at NREQ-1→0.
  - Ties are always resolved by this search order.
  - After reset, master 0 wins a simultaneous request.
- A revoked master whose req stays high re-enters arbitration at lowest priority. No sticky lockout.
- Request handling:
  - req dropping and re-asserting inside TURN counts as a new request.
  - req pulses shorter than one cycle, or dropped before a grant, are lost; no queuing.
  - A master must keep req high until it has finished its last strobe. It must deassert its strobes in the same cycle it drops req; the arbiter does not check this.
- Steady-state overhead is 2 cycles per handover: the TURN cycle plus the grant register cycle.
- Hold counter width is $clog2(MAX_HOLD+1) and it saturates; it never wraps.

Test Plan:
- Reset: nReset=0 with req=3'b111 → gnt=0, busy=0, nRead=nWrite=1, address=0. Release reset at edge 0 with req=3'b111 held → gnt=3'b001 after edge 1.
- Single master: master 1 raises req at edge 5 with m_address=16'h2011, m_nWrite=0 → gnt=3'b010, owner=1 after edge 6. Bus shows address=16'h2011, nWrite=0 in the same cycle.
- Round-robin: all three req held high, each releasing after 4 granted cycles → grant order 0,1,2,0. Exactly one idle bus cycle between owners; gnt is never multi-hot.
- Non-owner isolation: master 0 owns with nRead=1; master 2 drives m_nRead=0, m_address=16'h8003 → bus nRead stays 1, address = master 0's value.
- Timeout: MAX_HOLD=24, master 0 holds req for 30 cycles → gnt[0] drops after the 24th granted cycle. timeout_err=1 for exactly one cycle, timeout_idx=0; master 1 (req high) is granted 2 cycles later.
- Async reset mid-tenure: master 2 owns with nWrite=0, nReset pulsed low between edges → bus goes idle and gnt=0 immediately, without waiting for a clock edge. Next arbitration starts from pointer 0.
